load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 221 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : load_store_unit                                              |
// | Description : RV32I load/store unit. Accepts one request at a time,        |
// |               checks alignment and width codes, issues a single bus        |
// |               request to data memory and returns a one-cycle response.     |
// |               Optional macro LSU_TIMEOUT_EN adds a memory-response         |
// |               watchdog bounded by TIMEOUT_CYCLES.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_load_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [4:0]  req_rd_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_data_o,
    output logic [4:0]  resp_rd_o,
    output logic        resp_err_o,
    output logic        resp_misalign_o,
    output logic        busy_o,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_resp_valid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_resp_err_i
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_wait = 2'd2;
    localparam logic [1:0] c_st_resp = 2'd3;

    logic [1:0]  r_state;
    logic        r_load;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [4:0]  r_rd;
    logic        r_mem_req_valid;
    logic        r_resp_valid;
    logic [31:0] r_resp_data;
    logic [4:0]  r_resp_rd;
    logic        r_resp_err;
    logic        r_resp_misalign;

    logic        w_req_illegal;
    logic        w_req_misalign;
    logic        w_timeout;
    logic [31:0] w_lane;
    logic [31:0] w_load_data;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    // Width code decode of the incoming request: low two funct3 bits give the size.
    assign w_req_illegal  = req_load_i ? (req_funct3_i == 3'b011 || req_funct3_i == 3'b110 ||
                                          req_funct3_i == 3'b111)
                                       : (req_funct3_i > 3'b010);
    assign w_req_misalign = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                            ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));

`ifdef LSU_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_cnt_w-1:0] r_wd_cnt;

    // Watchdog: counts every cycle a transaction is outstanding on the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt <= '0;
        end else if (r_state == c_st_req || r_state == c_st_wait) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end else begin
            r_wd_cnt <= '0;
        end
    end

    // Fires on the last allowed cycle so the abort edge is the limit-th cycle.
    assign w_timeout = (r_wd_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));
`else
    localparam int c_unused_timeout = TIMEOUT_CYCLES;
    assign w_timeout = 1'b0;
`endif

    // Bring the addressed byte lane down to bit 0 of the read word.
    assign w_lane = mem_rdata_i >> {r_addr[1:0], 3'b000};

    // Sign- or zero-extend the selected lane according to the load width code.
    always_comb begin
        w_load_data = w_lane;
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
            3'b001:  w_load_data = {{16{w_lane[15]}}, w_lane[15:0]};
            3'b100:  w_load_data = {24'd0, w_lane[7:0]};
            3'b101:  w_load_data = {16'd0, w_lane[15:0]};
            default: w_load_data = w_lane;
        endcase
    end

    // Byte enables and replicated store data; loads share the same enable pattern.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = r_wdata;
        case (r_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wdata = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << r_addr[1:0];
                w_wdata = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = r_wdata;
            end
        endcase
    end

    // Transaction FSM with registered bus-valid and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= c_st_idle;
            r_load          <= 1'b0;
            r_funct3        <= 3'd0;
            r_addr          <= 32'd0;
            r_wdata         <= 32'd0;
            r_rd            <= 5'd0;
            r_mem_req_valid <= 1'b0;
            r_resp_valid    <= 1'b0;
            r_resp_data     <= 32'd0;
            r_resp_rd       <= 5'd0;
            r_resp_err      <= 1'b0;
            r_resp_misalign <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (req_valid_i) begin
                        r_load   <= req_load_i;
                        r_funct3 <= req_funct3_i;
                        r_addr   <= req_addr_i;
                        r_wdata  <= req_wdata_i;
                        r_rd     <= req_rd_i;
                        if (w_req_illegal || w_req_misalign) begin
                            // Rejected without touching the bus.
                            r_state         <= c_st_resp;
                            r_resp_valid    <= 1'b1;
                            r_resp_misalign <= 1'b1;
                            r_resp_err      <= 1'b0;
                            r_resp_data     <= 32'd0;
                            r_resp_rd       <= req_rd_i;
                        end else begin
                            r_state         <= c_st_req;
                            r_mem_req_valid <= 1'b1;
                        end
                    end
                end
                c_st_req: begin
                    if (w_timeout) begin
                        r_state         <= c_st_resp;
                        r_mem_req_valid <= 1'b0;
                        r_resp_valid    <= 1'b1;
                        r_resp_err      <= 1'b1;
                        r_resp_misalign <= 1'b0;
                        r_resp_data     <= 32'd0;
                        r_resp_rd       <= r_rd;
                    end else if (mem_req_ready_i) begin
                        r_state         <= c_st_wait;
                        r_mem_req_valid <= 1'b0;
                    end
                end
                c_st_wait: begin
                    if (mem_resp_valid_i) begin
                        r_state         <= c_st_resp;
                        r_resp_valid    <= 1'b1;
                        r_resp_err      <= mem_resp_err_i;
                        r_resp_misalign <= 1'b0;
                        r_resp_data     <= r_load ? w_load_data : 32'd0;
                        r_resp_rd       <= r_rd;
                    end else if (w_timeout) begin
                        r_state         <= c_st_resp;
                        r_resp_valid    <= 1'b1;
                        r_resp_err      <= 1'b1;
                        r_resp_misalign <= 1'b0;
                        r_resp_data     <= 32'd0;
                        r_resp_rd       <= r_rd;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign req_ready_o     = (r_state == c_st_idle) && !rst;
    assign busy_o          = (r_state != c_st_idle);
    assign mem_req_valid_o = r_mem_req_valid;
    assign mem_we_o        = ~r_load;
    assign mem_addr_o      = {r_addr[31:2], 2'b00};
    assign mem_be_o        = w_be;
    assign mem_wdata_o     = w_wdata;
    assign resp_valid_o    = r_resp_valid;
    assign resp_data_o     = r_resp_data;
    assign resp_rd_o       = r_resp_rd;
    assign resp_err_o      = r_resp_err;
    assign resp_misalign_o = r_resp_misalign;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_load_store_unit                                           |
// | Description : Scoreboard bench for load_store_unit with a reactive memory  |
// |               responder and a behavioural reference model.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_load_store_unit;

    localparam int TIMEOUT_CYCLES = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_load_i = 1'b0;
    logic [2:0]  req_funct3_i = 3'd0;
    logic [31:0] req_addr_i = 32'd0;
    logic [31:0] req_wdata_i = 32'd0;
    logic [4:0]  req_rd_i = 5'd0;
    logic        resp_valid_o;
    logic [31:0] resp_data_o;
    logic [4:0]  resp_rd_o;
    logic        resp_err_o;
    logic        resp_misalign_o;
    logic        busy_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i = 1'b0;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_resp_valid_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'd0;
    logic        mem_resp_err_i = 1'b0;

    load_store_unit #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_load_i(req_load_i), .req_funct3_i(req_funct3_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i),
        .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .resp_rd_o(resp_rd_o),
        .resp_err_o(resp_err_o), .resp_misalign_o(resp_misalign_o), .busy_o(busy_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_be_o(mem_be_o), .mem_resp_valid_i(mem_resp_valid_i),
        .mem_rdata_i(mem_rdata_i), .mem_resp_err_i(mem_resp_err_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        err;
        logic        mis;
        bit          chk_data;
        int          lat;
    } resp_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } bus_exp_t;

    resp_exp_t resp_q[$];
    bus_exp_t  bus_q[$];

    int  n_tests = 0;
    int  n_fail  = 0;
    time acc_time = 0;

    // Per-transaction memory behaviour, set by the driver before each request.
    int          cfg_rdy = 0;
    int          cfg_rsp = 0;
    logic [31:0] cfg_rdata = 32'd0;
    logic        cfg_err = 1'b0;
    int          force_req = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request; the reference model predicts the bus payload and response.
    task automatic issue(input bit ld, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd,
                         input int rdy, input int rsp, input logic [31:0] rdata,
                         input bit err, input bit exp_resp, input bit tmo);
        int          size;
        int          idx;
        bit          ill;
        bit          mis;
        logic [7:0]  be_wide;
        logic [31:0] v;
        logic [31:0] m;
        bus_exp_t    b;
        resp_exp_t   r;
        int          k;
        k = 0;
        while (!req_ready_o) begin
            tick();
            k++;
            if (k > 300) begin
                n_tests++;
                n_fail++;
                $display("FAIL req_ready_wait: ready never rose within 300 cycles");
                return;
            end
        end
        size = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
        idx  = int'(a[1:0]);
        ill  = ld ? (f == 3'd3 || f == 3'd6 || f == 3'd7) : (f > 3'd2);
        mis  = ill || ((idx % size) != 0);
        v = rdata >> (8 * idx);
        if (size < 4) begin
            m = (32'h1 << (8 * size)) - 32'h1;
            v = v & m;
            if (!f[2] && v[8 * size - 1]) v = v | ~m;
        end
        if (mis) begin
            r = '{data: 32'd0, rd: rd, err: 1'b0, mis: 1'b1, chk_data: 1'b0, lat: 1};
        end else begin
            be_wide = 8'(((1 << size) - 1) << idx);
            b.we    = !ld;
            b.addr  = a & 32'hFFFF_FFFC;
            b.be    = be_wide[3:0];
            b.wdata = (size == 1) ? {24'd0, wd[7:0]} * 32'h0101_0101 :
                      (size == 2) ? {16'd0, wd[15:0]} * 32'h0001_0001 : wd;
            bus_q.push_back(b);
            if (tmo)
                r = '{data: 32'd0, rd: rd, err: 1'b1, mis: 1'b0, chk_data: 1'b0,
                      lat: TIMEOUT_CYCLES + 1};
            else
                r = '{data: ld ? v : 32'd0, rd: rd, err: err, mis: 1'b0, chk_data: 1'b1,
                      lat: 3 + rdy + rsp};
        end
        if (exp_resp) resp_q.push_back(r);
        cfg_rdy      = rdy;
        cfg_rsp      = rsp;
        cfg_rdata    = rdata;
        cfg_err      = err;
        req_valid_i  = 1'b1;
        req_load_i   = ld;
        req_funct3_i = f;
        req_addr_i   = a;
        req_wdata_i  = wd;
        req_rd_i     = rd;
        @(posedge clk);
        acc_time = $time;
        #1;
        req_valid_i  = 1'b0;
        req_load_i   = 1'($urandom);
        req_funct3_i = 3'($urandom);
        req_addr_i   = $urandom;
        req_wdata_i  = $urandom;
        req_rd_i     = 5'($urandom);
    endtask

    // Memory responder: checks the bus payload every request cycle and replies
    // after the configured delays; stray response pulses are thrown in outside WAIT.
    int       r_ph = 0;
    int       r_cnt = 0;
    int       force_seen = 0;
    bus_exp_t cur;
    always @(negedge clk) begin
        if (rst) begin
            r_ph = 0;
            r_cnt = 0;
            mem_req_ready_i  = 1'b0;
            mem_resp_valid_i = 1'b0;
        end else if (r_ph == 0) begin
            if (mem_req_valid_o) begin
                if (r_cnt == 0) begin
                    chk("bus_req_expected", 64'(bus_q.size() != 0), 64'd1);
                    if (bus_q.size() != 0) cur = bus_q.pop_front();
                end
                chk("mem_we", 64'(mem_we_o), 64'(cur.we));
                chk("mem_addr", 64'(mem_addr_o), 64'(cur.addr));
                chk("mem_be", 64'(mem_be_o), 64'(cur.be));
                if (cur.we) chk("mem_wdata", 64'(mem_wdata_o), 64'(cur.wdata));
                mem_req_ready_i = (r_cnt >= cfg_rdy);
                if (mem_req_ready_i) begin
                    r_ph = 1;
                    r_cnt = 0;
                end else begin
                    r_cnt++;
                end
                mem_resp_valid_i = 1'($urandom);
                mem_rdata_i      = $urandom;
                mem_resp_err_i   = 1'($urandom);
            end else begin
                r_cnt = 0;
                mem_req_ready_i  = ($urandom_range(0, 3) == 0);
                mem_resp_valid_i = (force_req != force_seen) || ($urandom_range(0, 3) == 0);
                force_seen       = force_req;
                mem_rdata_i      = $urandom;
                mem_resp_err_i   = 1'($urandom);
            end
        end else begin
            mem_req_ready_i = 1'b0;
            if (!busy_o) begin
                r_ph = 0;
                r_cnt = 0;
                mem_resp_valid_i = 1'b0;
            end else begin
                chk("req_valid_dropped", 64'(mem_req_valid_o), 64'd0);
                if (r_cnt >= cfg_rsp) begin
                    mem_resp_valid_i = 1'b1;
                    mem_rdata_i      = cfg_rdata;
                    mem_resp_err_i   = cfg_err;
                    r_ph = 0;
                    r_cnt = 0;
                end else begin
                    mem_resp_valid_i = 1'b0;
                    r_cnt++;
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on each pulse and checks hold between pulses.
    logic [31:0] h_data = 32'd0;
    logic [4:0]  h_rd = 5'd0;
    logic        h_err = 1'b0;
    logic        h_mis = 1'b0;
    always @(negedge clk) begin
        resp_exp_t e;
        if (rst) begin
            h_data = 32'd0;
            h_rd   = 5'd0;
            h_err  = 1'b0;
            h_mis  = 1'b0;
        end else if (resp_valid_o) begin
            chk("resp_expected", 64'(resp_q.size() != 0), 64'd1);
            chk("no_bus_req_in_resp", 64'(mem_req_valid_o), 64'd0);
            if (resp_q.size() != 0) begin
                e = resp_q.pop_front();
                chk("resp_rd", 64'(resp_rd_o), 64'(e.rd));
                chk("resp_err", 64'(resp_err_o), 64'(e.err));
                chk("resp_misalign", 64'(resp_misalign_o), 64'(e.mis));
                if (e.chk_data) chk("resp_data", 64'(resp_data_o), 64'(e.data));
                chk("resp_latency", 64'(($time - acc_time + 5) / 10), 64'(e.lat));
            end
            h_data = resp_data_o;
            h_rd   = resp_rd_o;
            h_err  = resp_err_o;
            h_mis  = resp_misalign_o;
        end else begin
            chk("resp_hold", {resp_data_o, 25'd0, resp_rd_o, resp_err_o, resp_misalign_o},
                {h_data, 25'd0, h_rd, h_err, h_mis});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        int k;
        repeat (2) tick();
        chk("rst_ready_low", 64'(req_ready_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_mem_req_valid", 64'(mem_req_valid_o), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
        chk("rst_resp_fields", {resp_data_o, 25'd0, resp_rd_o, resp_err_o, resp_misalign_o}, 64'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 64'(req_ready_o), 64'd1);

        // Directed cases from the block's reference examples.
        issue(0, 3'b010, 32'h100, 32'hDEADBEEF, 5'd1, 0, 0, 32'd0, 1'b0, 1, 0);
        issue(0, 3'b000, 32'h103, 32'h000000A5, 5'd2, 0, 0, 32'd0, 1'b0, 1, 0);
        issue(1, 3'b000, 32'h102, 32'd0, 5'd3, 0, 0, 32'h12F03456, 1'b0, 1, 0);
        issue(1, 3'b100, 32'h102, 32'd0, 5'd4, 0, 0, 32'h12F03456, 1'b0, 1, 0);
        issue(1, 3'b010, 32'h101, 32'd0, 5'd5, 0, 0, 32'd0, 1'b0, 1, 0);
        issue(1, 3'b001, 32'h202, 32'd0, 5'd6, 3, 0, 32'h8001_7FFF, 1'b1, 1, 0);
        issue(0, 3'b011, 32'h200, 32'h1234, 5'd7, 0, 0, 32'd0, 1'b0, 1, 0);
        issue(1, 3'b110, 32'h200, 32'd0, 5'd8, 0, 0, 32'd0, 1'b0, 1, 0);
        issue(0, 3'b001, 32'h206, 32'hCAFE_BABE, 5'd9, 1, 2, 32'd0, 1'b0, 1, 0);

        // Reset while waiting for the memory: no response, late reply ignored.
        issue(1, 3'b010, 32'h300, 32'd0, 5'd10, 0, 1000, 32'd0, 1'b0, 0, 0);
        tick();
        tick();
        chk("in_wait_busy", 64'(busy_o), 64'd1);
        rst = 1'b1;
        tick();
        chk("midrst_ready_low", 64'(req_ready_o), 64'd0);
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_mem_req_valid", 64'(mem_req_valid_o), 64'd0);
        rst = 1'b0;
        force_req++;
        tick();
        chk("midrst_ready_after", 64'(req_ready_o), 64'd1);
        repeat (3) tick();
        chk("late_resp_ignored", 64'(busy_o), 64'd0);

`ifdef LSU_TIMEOUT_EN
        issue(1, 3'b010, 32'h400, 32'd0, 5'd11, 0, 100000, 32'd0, 1'b0, 1, 1);
        issue(0, 3'b010, 32'h404, 32'h1, 5'd12, 100000, 0, 32'd0, 1'b0, 1, 1);
`endif

        // Randomized traffic against the reference model.
        for (int i = 0; i < 200; i++) begin
            issue(1'($urandom), 3'($urandom), $urandom, $urandom, 5'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                  ($urandom_range(0, 7) == 0), 1, 0);
        end

        k = 0;
        while (resp_q.size() != 0 && k < 100) begin
            tick();
            k++;
        end
        repeat (3) tick();
        chk("resp_queue_drained", 64'(resp_q.size()), 64'd0);
        chk("bus_queue_drained", 64'(bus_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
